cipher_session_ctrl: RTL and testbench

//  Sequences one cipher_core instance for a whole message session. Folds a key string into the 8-bit seed.

---
 rtl/cipher_pkg.sv | 23 ++
 rtl/cipher_msg_buf.sv | 33 +++
 rtl/cipher_session_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_cipher_session_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher session controller.
// FSM state encoding, seed substitution value and drain timeout.
package cipher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_LOAD,
        ST_ARM,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [7:0] SEED_ZERO_SUB = 8'h01;
    localparam int         DRAIN_TIMEOUT = 4;

    // A folded key of zero would give a degenerate keystream, so substitute a fixed seed.
    function automatic logic [7:0] fold_seed(input logic [7:0] acc);
        return (acc == 8'h00) ? SEED_ZERO_SUB : acc;
    endfunction

endpackage

// File: rtl/cipher_msg_buf.sv
// Message buffer: DEPTH x 8 register file, one write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller owns pointer management.
module cipher_msg_buf
    import cipher_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_dat
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/cipher_session_ctrl.sv
// Cipher session sequencer: folds key to seed, buffers message, streams it through cipher_core.
// Latency: core_ch issued back-to-back from the cycle after core_start; out_byte one cycle after core_valid_out.
// Backpressure: key_ready/in_ready gate the host streams; output side has none. Optional CIPHER_CTRL_XSUM_EN.
module cipher_session_ctrl
    import cipher_pkg::*;
#(
    parameter int KEY_MAX_LEN = 32,
    parameter int MSG_DEPTH   = 16,
    parameter int LEN_W       = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [7:0]       key_byte,
    input  logic             key_last,
    output logic             key_ready,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             go,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_byte,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       out_xsum,
    output logic             core_start,
    output logic [7:0]       core_seed,
    output logic [7:0]       core_ch,
    input  logic [7:0]       core_ch_out,
    input  logic             core_valid_out
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int KW = $clog2(KEY_MAX_LEN + 2);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(MSG_DEPTH);
    localparam logic [KW-1:0]    KEY_LIM = KW'(KEY_MAX_LEN);
    localparam logic [TW-1:0]    TO_LAST = TW'(DRAIN_TIMEOUT - 1);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] rd;
    logic [LEN_W-1:0] out_cnt;
    logic [7:0]       acc;
    logic [KW-1:0]    key_cnt;
    logic [TW-1:0]    idle_cnt;

    logic             key_fire;
    logic             in_fire;
    logic             cap;
    logic [7:0]       acc_next;
    logic [LEN_W-1:0] out_cnt_next;
    logic [7:0]       rd_dat;

    assign key_ready    = (state == ST_KEY);
    assign in_ready     = (state == ST_LOAD) && (fill < len);
    assign busy         = (state != ST_IDLE);
    assign key_fire     = key_valid && key_ready;
    assign in_fire      = in_valid && in_ready;
    assign cap          = core_valid_out && ((state == ST_STREAM) || (state == ST_DRAIN));
    assign acc_next     = (key_byte != 8'h00) ? (acc ^ key_byte) : acc;
    assign out_cnt_next = out_cnt + LEN_W'(cap);

    cipher_msg_buf #(
        .DEPTH (MSG_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (in_fire),
        .wr_addr (fill[AW-1:0]),
        .wr_dat  (in_byte),
        .rd_addr (rd[AW-1:0]),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            len        <= '0;
            fill       <= '0;
            rd         <= '0;
            out_cnt    <= '0;
            acc        <= 8'h00;
            key_cnt    <= '0;
            idle_cnt   <= '0;
            out_valid  <= 1'b0;
            out_byte   <= 8'h00;
            done       <= 1'b0;
            err        <= 1'b0;
            core_start <= 1'b0;
            core_seed  <= SEED_ZERO_SUB;
            core_ch    <= 8'h00;
        end else begin
            core_start <= 1'b0;
            done       <= 1'b0;
            out_valid  <= cap;
            if (cap) begin
                out_byte <= core_ch_out;
                out_cnt  <= out_cnt_next;
            end
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        if (msg_len > DEPTH_L) begin
                            len <= DEPTH_L;
                            err <= 1'b1;
                        end else begin
                            len <= msg_len;
                            err <= 1'b0;
                        end
                        acc      <= 8'h00;
                        key_cnt  <= '0;
                        fill     <= '0;
                        rd       <= '0;
                        out_cnt  <= '0;
                        idle_cnt <= '0;
                        state    <= ST_KEY;
                    end
                end
                ST_KEY: begin
                    if (key_fire) begin
                        if (key_cnt == KEY_LIM) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            key_cnt <= key_cnt + 1'b1;
                            acc     <= acc_next;
                            if (key_last) begin
                                core_seed <= fold_seed(acc_next);
                                if (len == '0) begin
                                    done  <= 1'b1;
                                    state <= ST_DONE;
                                end else begin
                                    state <= ST_LOAD;
                                end
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_fire) begin
                        fill <= fill + 1'b1;
                        if (fill + 1'b1 == len) begin
                            core_start <= 1'b1;
                            state      <= ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    // Preload the first byte so it meets the core on the first keystream step.
                    core_ch <= rd_dat;
                    rd      <= rd + 1'b1;
                    state   <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (rd == len) begin
                        state <= ST_DRAIN;
                    end else begin
                        core_ch <= rd_dat;
                        rd      <= rd + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    idle_cnt <= cap ? '0 : idle_cnt + 1'b1;
                    if (out_cnt_next == len) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (!cap && (idle_cnt == TO_LAST)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    fill  <= '0;
                    rd    <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CIPHER_CTRL_XSUM_EN
    logic [7:0] xsum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xsum <= 8'h00;
        end else if ((state == ST_IDLE) && go) begin
            xsum <= 8'h00;
        end else if (cap) begin
            xsum <= xsum ^ core_ch_out;
        end
    end

    assign out_xsum = xsum;
`else
    assign out_xsum = 8'h00;
`endif

endmodule

// File: tb/tb_cipher_session_ctrl.sv
// Bench for cipher_session_ctrl with a behavioural XOR-keystream core and a queue scoreboard.
`timescale 1ns/1ps
module tb_cipher_session_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid, key_last, key_ready;
    logic [7:0] key_byte;
    logic [4:0] msg_len;
    logic       go;
    logic       in_valid, in_ready;
    logic [7:0] in_byte;
    logic       out_valid, busy, done, err;
    logic [7:0] out_byte, out_xsum;
    logic       core_start, core_valid_out;
    logic [7:0] core_seed, core_ch, core_ch_out;

    always #5 clk = ~clk;

    cipher_session_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_valid      (key_valid),
        .key_byte       (key_byte),
        .key_last       (key_last),
        .key_ready      (key_ready),
        .msg_len        (msg_len),
        .go             (go),
        .in_valid       (in_valid),
        .in_byte        (in_byte),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_byte       (out_byte),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .out_xsum       (out_xsum),
        .core_start     (core_start),
        .core_seed      (core_seed),
        .core_ch        (core_ch),
        .core_ch_out    (core_ch_out),
        .core_valid_out (core_valid_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing, required it to occur", name);
    endtask

    // Keystream of the stand-in core: step i of a session seeded with seed.
    function automatic logic [7:0] ks(input logic [7:0] seed, input int i);
        return seed ^ 8'((i * 29) + 7);
    endfunction

    // Behavioural cipher core: one-cycle latency, keystream advances every cycle after start.
    int         core_n;
    logic       core_mute;
    logic [7:0] cs;
    int         ci, cleft;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_valid_out <= 1'b0;
            core_ch_out    <= 8'h00;
            cs             <= 8'h00;
            ci             <= 0;
            cleft          <= 0;
        end else begin
            core_valid_out <= 1'b0;
            if (core_start) begin
                cs    <= core_seed;
                ci    <= 0;
                cleft <= core_n;
            end else if (cleft > 0) begin
                core_ch_out    <= core_ch ^ ks(cs, ci);
                core_valid_out <= !core_mute;
                ci             <= ci + 1;
                cleft          <= cleft - 1;
            end
        end
    end

    typedef struct {
        logic [7:0] seed;
        bit         chk_seed;
        int         starts;
        bit         err;
        logic [7:0] xsum;
    } sess_t;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    sess_t      sess_q[$];
    int         done_seen = 0;
    int         start_cnt = 0;
    bit         sb_on = 1'b1;

    always @(negedge clk) begin
        sess_t      s;
        logic [7:0] e;
        if (done) done_seen++;
        if (!sb_on) begin
            start_cnt = 0;
        end else begin
            if (core_start) start_cnt++;
            if (out_valid) begin
                got_q.push_back(out_byte);
                if (exp_q.size() == 0) begin
                    fail("unexpected_out_valid");
                end else begin
                    e = exp_q.pop_front();
                    chk("out_byte", out_byte, e);
                end
            end
            if (done) begin
                if (sess_q.size() == 0) begin
                    fail("session_record_for_done");
                end else begin
                    s = sess_q.pop_front();
                    chk("err_at_done", err, s.err);
                    chk("core_start_pulses", start_cnt, s.starts);
                    chk("missing_out_bytes", exp_q.size(), 0);
                    if (s.chk_seed) chk("core_seed", core_seed, s.seed);
                    chk("out_xsum", out_xsum, s.xsum);
                end
                exp_q.delete();
                start_cnt = 0;
            end
        end
    end

    logic [7:0] key_q[$];
    logic [7:0] msg_q[$];

    task automatic load_key(input string str);
        key_q.delete();
        for (int i = 0; i < str.len(); i++) key_q.push_back(str[i]);
    endtask

    task automatic load_msg(input string str);
        msg_q.delete();
        for (int i = 0; i < str.len(); i++) msg_q.push_back(str[i]);
    endtask

    task automatic send_key();
        int w;
        for (int i = 0; i < key_q.size(); i++) begin
            key_valid = 1'b1;
            key_byte  = key_q[i];
            key_last  = (i == key_q.size() - 1);
            w = 0;
            while (!key_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!key_ready) begin
                fail("key_ready_timeout");
                break;
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        key_last  = 1'b0;
        key_byte  = 8'h00;
    endtask

    task automatic send_msg(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_byte  = msg_q[i];
            w = 0;
            while (!in_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                fail("in_ready_timeout");
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic run_session(input int len, input bit mute, input bit poke_go);
        sess_t      s;
        logic [7:0] acc;
        int         eff, d0, n;
        bit         abort;
        acc = 8'h00;
        foreach (key_q[i]) if (key_q[i] != 8'h00) acc ^= key_q[i];
        abort      = key_q.size() > 32;
        eff        = (len > 16) ? 16 : len;
        s.seed     = (acc == 8'h00) ? 8'h01 : acc;
        s.chk_seed = !abort;
        s.starts   = (!abort && eff > 0) ? 1 : 0;
        s.err      = (len > 16) || abort || (mute && s.starts == 1);
        s.xsum     = 8'h00;
        if (s.starts == 1 && !mute) begin
            for (int i = 0; i < eff; i++) begin
                logic [7:0] o = msg_q[i] ^ ks(s.seed, i);
                exp_q.push_back(o);
                s.xsum ^= o;
            end
        end
`ifndef CIPHER_CTRL_XSUM_EN
        s.xsum = 8'h00;
`endif
        sess_q.push_back(s);
        core_n    = eff;
        core_mute = mute;
        got_q.delete();
        d0 = done_seen;
        go      = 1'b1;
        msg_len = len[4:0];
        @(negedge clk);
        go = 1'b0;
        chk("busy_after_go", busy, 1);
        send_key();
        if (abort || eff == 0) chk("done_after_key", done, 1);
        if (!abort && eff > 0) begin
            if (poke_go) begin
                go      = 1'b1;
                msg_len = 5'd3;
                @(negedge clk);
                go = 1'b0;
            end
            send_msg(eff);
        end
        n = 0;
        while (done_seen == d0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (done_seen == d0) fail("done_timeout");
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] orig[$];
        int         d0, n;
        rst_n = 1'b0; go = 1'b0; msg_len = '0;
        key_valid = 1'b0; key_byte = 8'h00; key_last = 1'b0;
        in_valid = 1'b0; in_byte = 8'h00;
        core_n = 0; core_mute = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_key_ready", key_ready, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_seed", core_seed, 8'h01);
        chk("rst_core_ch", core_ch, 0);
        chk("rst_out_xsum", out_xsum, 0);
        rst_n = 1'b1;
        @(negedge clk);

        load_key("Tintareanu");
        load_msg("Paula#&0123TestX");
        orig = msg_q;
        run_session(16, 0, 0);
        chk("seed_tintareanu", core_seed, 8'h2B);
        chk("s1_out_count", got_q.size(), 16);

        msg_q = got_q;
        run_session(16, 0, 0);
        chk("roundtrip_count", got_q.size(), 16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) chk("roundtrip_byte", got_q[i], orig[i]);

        load_key("AA");
        load_msg("hello");
        run_session(5, 0, 0);
        chk("seed_zero_sub", core_seed, 8'h01);

        key_q = '{8'h00, 8'h4B, 8'h00, 8'h65, 8'h00, 8'h79};
        load_msg("nullkey");
        run_session(7, 0, 0);
        chk("seed_nulls", core_seed, 8'h4B ^ 8'h65 ^ 8'h79);

        load_key("Zero");
        run_session(0, 0, 0);

        key_q.delete();
        for (int i = 0; i < 33; i++) key_q.push_back(8'($urandom_range(1, 255)));
        load_msg("abcd");
        run_session(4, 0, 0);

        load_key("Mute");
        load_msg("silent");
        run_session(6, 1, 0);

        load_key("Busy");
        load_msg("ignore_go");
        run_session(9, 0, 1);

        load_key("Clamp");
        msg_q.delete();
        for (int i = 0; i < 20; i++) msg_q.push_back(8'($urandom));
        run_session(20, 0, 0);

        load_key("K");
        msg_q = '{8'h01, 8'h02};
        run_session(2, 0, 0);

        for (int r = 0; r < 8; r++) begin
            int kl;
            kl = $urandom_range(1, 10);
            key_q.delete();
            for (int i = 0; i < kl; i++)
                key_q.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
            msg_q.delete();
            for (int i = 0; i < 20; i++) msg_q.push_back(8'($urandom));
            run_session($urandom_range(0, 20), 0, 0);
        end

        load_key("Rst");
        load_msg("reset_midway");
        sb_on     = 1'b0;
        core_n    = 12;
        core_mute = 1'b0;
        go        = 1'b1;
        msg_len   = 5'd12;
        @(negedge clk);
        go = 1'b0;
        send_key();
        send_msg(12);
        n = 0;
        while (!core_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!core_start) fail("core_start_before_reset");
        repeat (3) @(negedge clk);
        chk("pre_rst_out_valid", out_valid, 1);
        d0 = done_seen;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_core_ch", core_ch, 0);
        chk("async_rst_out_byte", out_byte, 0);
        chk("async_rst_core_seed", core_seed, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_done_after_rst", done_seen, d0);
        chk("idle_after_rst", busy, 0);
        sb_on = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
